// File: rtl/cnt_reload_seq_pkg.sv
// Shared types and constants for the counter reload sequencer.
// The watchdog feature is enabled by defining CNT_RELOAD_SEQ_WDOG_EN.
package cnt_reload_seq_pkg;

   // Sequencer states; IDLE must stay the all-zero encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      BLANK = 2'd2,
      RUN   = 2'd3
   } state_t;

   // One dead cycle after a load while the counter's rc is still stale.
   localparam int BLANK_CYCLES = 1;

   // Watchdog slack beyond the programmed period before declaring a fault.
   localparam int WDOG_MARGIN = 4;

endpackage

// File: rtl/cnt_reload_seq_wdog.sv
// Watchdog for the reload sequencer: counts cycles since the last load and
// flags when the count passes period + WDOG_MARGIN without a terminal event.
// Only instantiated when CNT_RELOAD_SEQ_WDOG_EN is defined.
module cnt_reload_seq_wdog
   import cnt_reload_seq_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   input  logic [W-1:0] period,
   output logic         expired
);

   // Two extra bits so period + margin can never overflow the counter.
   logic [W+1:0] cnt;
   logic [W+1:0] limit;

   assign limit   = {2'b00, period} + (W+2)'(WDOG_MARGIN);
   assign expired = (cnt > limit);

   // Cycle counter: cleared in LOAD, advanced in BLANK/RUN.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cnt_reload_seq.sv
// Counter reload sequencer: programs an external up/down loadable counter
// with a period, counts its terminal events and reloads it until the
// requested number of events has been seen, then pulses done.
// Optional watchdog: define CNT_RELOAD_SEQ_WDOG_EN.
//
// Handshake: start is a level sampled only in IDLE while busy is low; one
// accepted start produces either exactly one done pulse, an abort (no done),
// or a watchdog error (no done). busy stays high through the done cycle.
module cnt_reload_seq
   import cnt_reload_seq_pkg::*;
#(
   parameter int W  = 32,
   parameter int EW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [W-1:0]  period,
   input  logic          dir,
   input  logic [EW-1:0] repeat_n,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [EW-1:0] event_cnt,
   output logic          ctr_load,
   output logic [W-1:0]  ctr_pdata,
   output logic          ctr_s,
   input  logic          ctr_rc
);

   state_t        state;
   logic [EW-1:0] rep_q;
   logic [EW-1:0] ev_next;
   logic          wdog_expired;

   // Saturating event increment; never wraps back to zero.
   assign ev_next = (event_cnt == '1) ? event_cnt : event_cnt + 1'b1;

`ifdef CNT_RELOAD_SEQ_WDOG_EN
   logic [W-1:0] period_q;

   cnt_reload_seq_wdog #(
      .W (W)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == LOAD),
      .inc     ((state == BLANK) || (state == RUN)),
      .period  (period_q),
      .expired (wdog_expired)
   );
`else
   assign wdog_expired = 1'b0;
`endif

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         event_cnt <= '0;
         ctr_load  <= 1'b0;
         ctr_pdata <= '0;
         ctr_s     <= 1'b0;
         rep_q     <= '0;
`ifdef CNT_RELOAD_SEQ_WDOG_EN
         period_q  <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               ctr_load <= 1'b0;
               busy     <= 1'b0;
               // busy still high here means the done cycle; start is ignored.
               if (start && !busy) begin
                  rep_q     <= (repeat_n == '0) ? EW'(1) : repeat_n;
                  event_cnt <= '0;
                  err       <= 1'b0;
                  ctr_s     <= dir;
                  // Up-counting loads ~period so both directions hit their
                  // terminal value after the same number of steps.
                  ctr_pdata <= dir ? ~period : period;
                  ctr_load  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= LOAD;
`ifdef CNT_RELOAD_SEQ_WDOG_EN
                  period_q  <= period;
`endif
               end
            end
            LOAD: begin
               ctr_load <= 1'b0;
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= BLANK;
               end
            end
            BLANK: begin
               // rc is not refreshed by a load, so it is ignored here.
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (ctr_rc) begin
                  event_cnt <= ev_next;
                  if (ev_next == rep_q) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     ctr_load <= 1'b1;
                     state    <= LOAD;
                  end
               end else if (wdog_expired) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy     <= 1'b0;
               ctr_load <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cnt_reload_seq.sv
// Directed bench for cnt_reload_seq with a behavioural up/down loadable
// counter attached to the counter interface.
module tb_cnt_reload_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] period = '0;
   logic        dir = 1'b0;
   logic [7:0]  repeat_n = '0;
   logic        busy, done, err;
   logic [7:0]  event_cnt;
   logic        ctr_load;
   logic [31:0] ctr_pdata;
   logic        ctr_s;
   logic        ctr_rc;

   int n_checks = 0;
   int n_errors = 0;

   // Counter model and its test hooks.
   logic [31:0] mcnt = 32'd1;
   logic        mrc = 1'b0;
   logic        mdl_force = 1'b0;
   logic        mdl_kill = 1'b0;

   // Per-cycle history of one sequence, index 0 = LOAD cycle.
   logic [63:0] load_h, done_h, busy_h, rc_h, s_h, err_h;
   logic [7:0]  ev_h [64];
   logic [31:0] pdata_h [64];

   always #5 clk = ~clk;

   cnt_reload_seq #(.W(32), .EW(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .period    (period),
      .dir       (dir),
      .repeat_n  (repeat_n),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .event_cnt (event_cnt),
      .ctr_load  (ctr_load),
      .ctr_pdata (ctr_pdata),
      .ctr_s     (ctr_s),
      .ctr_rc    (ctr_rc)
   );

   always @(posedge clk) begin
      if (ctr_load) begin
         mcnt <= ctr_pdata;
      end else begin
         mcnt <= ctr_s ? mcnt + 32'd1 : mcnt - 32'd1;
         mrc  <= (mcnt == 32'd0) || (mcnt == 32'hFFFF_FFFF);
      end
   end

   assign ctr_rc = mdl_force | (mrc & ~mdl_kill);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: issues start, then records ncyc cycles from LOAD.
   task automatic run_seq(input logic [31:0] p, input logic d, input logic [7:0] r,
                          input int ncyc, input int force_upto, input int abort_at,
                          input int rst_at);
      load_h = '0; done_h = '0; busy_h = '0; rc_h = '0; s_h = '0; err_h = '0;
      period = p; dir = d; repeat_n = r; start = 1'b1;
      mdl_force = (force_upto >= 0);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         mdl_force  = (c <= force_upto);
         abort      = (c == abort_at);
         rst        = (c == rst_at);
         load_h[c]  = ctr_load;
         done_h[c]  = done;
         busy_h[c]  = busy;
         rc_h[c]    = ctr_rc;
         s_h[c]     = ctr_s;
         err_h[c]   = err;
         ev_h[c]    = event_cnt;
         pdata_h[c] = ctr_pdata;
         @(negedge clk);
      end
      abort = 1'b0; rst = 1'b0; mdl_force = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ev", event_cnt, 0);
      chk("rst_load", ctr_load, 0);
      chk("rst_pdata", ctr_pdata, 0);
      chk("rst_s", ctr_s, 0);
      @(negedge clk);

      // Down mode: period 5, three events, 8-cycle spacing
      run_seq(32'd5, 1'b0, 8'd3, 30, -1, -1, -1);
      chk("dn_pdata", pdata_h[0], 32'd5);
      chk("dn_load0", load_h[0], 1);
      chk("dn_load1", load_h[8], 1);
      chk("dn_load2", load_h[16], 1);
      chk("dn_nload", $countones(load_h), 3);
      for (int k = 0; k < 3; k++) begin
         chk("dn_rc_rise", {rc_h[6 + 8 * k], rc_h[7 + 8 * k]}, 2'b01);
      end
      chk("dn_ev1", ev_h[8], 1);
      chk("dn_done_at", done_h[24], 1);
      chk("dn_ndone", $countones(done_h), 1);
      chk("dn_busy_done", busy_h[24], 1);
      chk("dn_busy_fall", busy_h[25], 0);
      chk("dn_ev", ev_h[25], 3);

      // Up mode: period 2, single event
      run_seq(32'd2, 1'b1, 8'd1, 10, -1, -1, -1);
      chk("up_pdata", pdata_h[0], 32'hFFFF_FFFD);
      chk("up_rc", rc_h[4], 1);
      chk("up_done_at", done_h[5], 1);
      chk("up_ndone", $countones(done_h), 1);
      chk("up_s", s_h[9:0], 10'h3FF);
      chk("up_ev", ev_h[6], 1);
      chk("up_busy_fall", busy_h[6], 0);
      repeat (2) @(negedge clk);
      chk("idle_s_held", ctr_s, 1);

      // Edge values: period 0, repeat 0 treated as 1
      run_seq(32'd0, 1'b0, 8'd0, 8, -1, -1, -1);
      chk("e0_pdata", pdata_h[0], 0);
      chk("e0_rc", rc_h[2], 1);
      chk("e0_done_at", done_h[3], 1);
      chk("e0_ndone", $countones(done_h), 1);
      chk("e0_nload", $countones(load_h), 1);
      chk("e0_ev", ev_h[4], 1);

      // Stale rc held high through LOAD and BLANK is not counted
      run_seq(32'd5, 1'b0, 8'd2, 20, 1, -1, -1);
      chk("st_ev_blank", ev_h[2], 0);
      chk("st_ev_run", ev_h[3], 0);
      chk("st_ev1", ev_h[8], 1);
      chk("st_done_at", done_h[16], 1);
      chk("st_ev", ev_h[17], 2);

      // Abort in the RUN cycle of the final rc
      run_seq(32'd2, 1'b0, 8'd2, 14, -1, 9, -1);
      chk("ab_busy_pre", busy_h[9], 1);
      chk("ab_rc_last", rc_h[9], 1);
      chk("ab_ndone", $countones(done_h), 0);
      chk("ab_ev", ev_h[10], 1);
      chk("ab_busy", busy_h[10], 0);
      chk("ab_nload", $countones(load_h), 2);

      // Abort while idle has no effect
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_idle_busy", busy, 0);
      chk("ab_idle_ev", event_cnt, 1);
      chk("ab_idle_load", ctr_load, 0);

      // Reset mid-RUN, then a normal sequence two cycles later
      run_seq(32'd5, 1'b0, 8'd3, 6, -1, -1, 3);
      chk("mr_busy", busy_h[4], 0);
      chk("mr_done", done_h[4], 0);
      chk("mr_err", err_h[4], 0);
      chk("mr_ev", ev_h[4], 0);
      chk("mr_load", load_h[4], 0);
      chk("mr_pdata", pdata_h[4], 0);
      chk("mr_s", s_h[4], 0);
      run_seq(32'd1, 1'b0, 8'd2, 12, -1, -1, -1);
      chk("mr2_load0", load_h[0], 1);
      chk("mr2_load1", load_h[4], 1);
      chk("mr2_done_at", done_h[8], 1);
      chk("mr2_ev", ev_h[9], 2);

      // Counter that never reaches its terminal count
      mdl_kill = 1'b1;
      run_seq(32'd3, 1'b0, 8'd1, 16, -1, -1, -1);
`ifdef CNT_RELOAD_SEQ_WDOG_EN
      chk("wd_err_pre", err_h[9], 0);
      chk("wd_err", err_h[10], 1);
      chk("wd_busy", busy_h[10], 0);
      chk("wd_ndone", $countones(done_h), 0);
`else
      chk("wd_err", err_h[15:0], 16'h0000);
      chk("wd_busy", busy_h[15], 1);
      chk("wd_ndone", $countones(done_h), 0);
`endif
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      mdl_kill = 1'b0;
      chk("wd_end_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
